// File: rtl/point_add_arbiter.sv
// Two-port arbiter sharing one PointAdd datapath; captures operands, pulses start, returns result/done.
// Define PADD_ARB_RR_EN for round-robin tie-breaking; default build uses fixed priority (port 0).
module point_add_arbiter #(
    parameter int unsigned WIDTH = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_dbl,
    input  logic [1:0][WIDTH-1:0] i_x1,
    input  logic [1:0][WIDTH-1:0] i_y1,
    input  logic [1:0][WIDTH-1:0] i_z1,
    input  logic [1:0][WIDTH-1:0] i_x2,
    input  logic [1:0][WIDTH-1:0] i_y2,
    input  logic [1:0][WIDTH-1:0] i_z2,
    output logic [1:0]            o_ack,
    output logic [1:0]            o_done,
    output logic [WIDTH-1:0]      o_x3,
    output logic [WIDTH-1:0]      o_y3,
    output logic [WIDTH-1:0]      o_z3,
    output logic                  o_busy,
    output logic                  o_owner,
    output logic                  o_pa_start,
    output logic                  o_pa_doubling,
    output logic [WIDTH-1:0]      o_pa_x1,
    output logic [WIDTH-1:0]      o_pa_y1,
    output logic [WIDTH-1:0]      o_pa_z1,
    output logic [WIDTH-1:0]      o_pa_x2,
    output logic [WIDTH-1:0]      o_pa_y2,
    output logic [WIDTH-1:0]      o_pa_z2,
    input  logic [WIDTH-1:0]      i_pa_x3,
    input  logic [WIDTH-1:0]      i_pa_y3,
    input  logic [WIDTH-1:0]      i_pa_z3,
    input  logic                  i_pa_finished
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_nxt;
    logic              win;
    logic [1:0]        ack_nxt, done_nxt;
    logic              busy_nxt, owner_nxt, start_nxt, dbl_nxt;
    logic [WIDTH-1:0]  x1_nxt, y1_nxt, z1_nxt, x2_nxt, y2_nxt, z2_nxt;
    logic [WIDTH-1:0]  x3_nxt, y3_nxt, z3_nxt;

`ifdef PADD_ARB_RR_EN
    logic last_q, last_nxt;

    // On a tie the port not served last wins.
    always_comb begin
        win = (&i_req) ? ~last_q : i_req[1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) last_q <= 1'b1;
        else       last_q <= last_nxt;
    end
`else
    // Fixed priority: port 0 wins whenever it requests.
    always_comb begin
        win = ~i_req[0];
    end
`endif

    // Next-state and next-output values.
    always_comb begin
        state_nxt = state_q;
        ack_nxt   = 2'b00;
        done_nxt  = 2'b00;
        start_nxt = 1'b0;
        busy_nxt  = o_busy;
        owner_nxt = o_owner;
        dbl_nxt   = o_pa_doubling;
        x1_nxt    = o_pa_x1;
        y1_nxt    = o_pa_y1;
        z1_nxt    = o_pa_z1;
        x2_nxt    = o_pa_x2;
        y2_nxt    = o_pa_y2;
        z2_nxt    = o_pa_z2;
        x3_nxt    = o_x3;
        y3_nxt    = o_y3;
        z3_nxt    = o_z3;
`ifdef PADD_ARB_RR_EN
        last_nxt  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    state_nxt = BUSY;
                    ack_nxt   = 2'(2'b01 << win);
                    start_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    owner_nxt = win;
                    dbl_nxt   = i_dbl[win];
                    x1_nxt    = i_x1[win];
                    y1_nxt    = i_y1[win];
                    z1_nxt    = i_z1[win];
                    x2_nxt    = i_x2[win];
                    y2_nxt    = i_y2[win];
                    z2_nxt    = i_z2[win];
`ifdef PADD_ARB_RR_EN
                    last_nxt  = win;
`endif
                end
            end
            BUSY: begin
                if (i_pa_finished) begin
                    state_nxt = IDLE;
                    done_nxt  = 2'(2'b01 << o_owner);
                    busy_nxt  = 1'b0;
                    x3_nxt    = i_pa_x3;
                    y3_nxt    = i_pa_y3;
                    z3_nxt    = i_pa_z3;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            o_ack         <= 2'b00;
            o_done        <= 2'b00;
            o_pa_start    <= 1'b0;
            o_busy        <= 1'b0;
            o_owner       <= 1'b0;
            o_pa_doubling <= 1'b0;
            o_pa_x1       <= '0;
            o_pa_y1       <= '0;
            o_pa_z1       <= '0;
            o_pa_x2       <= '0;
            o_pa_y2       <= '0;
            o_pa_z2       <= '0;
            o_x3          <= '0;
            o_y3          <= '0;
            o_z3          <= '0;
        end else begin
            state_q       <= state_nxt;
            o_ack         <= ack_nxt;
            o_done        <= done_nxt;
            o_pa_start    <= start_nxt;
            o_busy        <= busy_nxt;
            o_owner       <= owner_nxt;
            o_pa_doubling <= dbl_nxt;
            o_pa_x1       <= x1_nxt;
            o_pa_y1       <= y1_nxt;
            o_pa_z1       <= z1_nxt;
            o_pa_x2       <= x2_nxt;
            o_pa_y2       <= y2_nxt;
            o_pa_z2       <= z2_nxt;
            o_x3          <= x3_nxt;
            o_y3          <= y3_nxt;
            o_z3          <= z3_nxt;
        end
    end

endmodule

// File: tb/tb_point_add_arbiter.sv
// Directed bench for point_add_arbiter; PointAdd is modelled by driving i_pa_finished and results.
`timescale 1ns/1ps
module tb_point_add_arbiter;
    localparam int unsigned W = 16;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [1:0]        i_req, i_dbl;
    logic [1:0][W-1:0] i_x1, i_y1, i_z1, i_x2, i_y2, i_z2;
    logic [1:0]        o_ack, o_done;
    logic [W-1:0]      o_x3, o_y3, o_z3;
    logic              o_busy, o_owner, o_pa_start, o_pa_doubling;
    logic [W-1:0]      o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2;
    logic [W-1:0]      i_pa_x3, i_pa_y3, i_pa_z3;
    logic              i_pa_finished;

    int checks = 0;
    int failures = 0;

    point_add_arbiter #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_dbl(i_dbl),
        .i_x1(i_x1), .i_y1(i_y1), .i_z1(i_z1), .i_x2(i_x2), .i_y2(i_y2), .i_z2(i_z2),
        .o_ack(o_ack), .o_done(o_done), .o_x3(o_x3), .o_y3(o_y3), .o_z3(o_z3),
        .o_busy(o_busy), .o_owner(o_owner), .o_pa_start(o_pa_start),
        .o_pa_doubling(o_pa_doubling),
        .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1), .o_pa_z1(o_pa_z1),
        .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2), .o_pa_z2(o_pa_z2),
        .i_pa_x3(i_pa_x3), .i_pa_y3(i_pa_y3), .i_pa_z3(i_pa_z3),
        .i_pa_finished(i_pa_finished)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_req = 2'b00; i_dbl = 2'b00; i_pa_finished = 1'b0;
        i_x1 = '0; i_y1 = '0; i_z1 = '0; i_x2 = '0; i_y2 = '0; i_z2 = '0;
        i_pa_x3 = '0; i_pa_y3 = '0; i_pa_z3 = '0;
        tick(); tick();
        i_rst = 1'b0;
        checks++;
        if ({o_ack, o_done, o_busy, o_owner, o_pa_start, o_pa_doubling} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {o_ack, o_done, o_busy, o_owner, o_pa_start, o_pa_doubling});
        end
        checks++;
        if ({o_x3, o_y3, o_z3, o_pa_x1, o_pa_z2} !== '0) begin
            failures++;
            $display("FAIL reset_data: x3=%0d y3=%0d z3=%0d pa_x1=%0d pa_z2=%0d expected all 0",
                     o_x3, o_y3, o_z3, o_pa_x1, o_pa_z2);
        end
    endtask

    task automatic test_single();
        i_req = 2'b10; i_dbl = 2'b10;
        i_x1[1] = 16'd9; i_y1[1] = 16'd14; i_z1[1] = 16'd1;
        tick();
        checks++;
        if ({o_ack, o_pa_start, o_busy, o_owner} !== 5'b10111) begin
            failures++;
            $display("FAIL single_ack: ack/start/busy/owner=%b expected 10111",
                     {o_ack, o_pa_start, o_busy, o_owner});
        end
        checks++;
        if (o_pa_x1 !== 16'd9 || o_pa_y1 !== 16'd14 || o_pa_z1 !== 16'd1 || o_pa_doubling !== 1'b1) begin
            failures++;
            $display("FAIL single_ops: pa=(%0d,%0d,%0d) dbl=%b expected (9,14,1) dbl=1",
                     o_pa_x1, o_pa_y1, o_pa_z1, o_pa_doubling);
        end
        i_req = 2'b00;
        tick();
        checks++;
        if ({o_ack, o_pa_start, o_busy} !== 4'b0001) begin
            failures++;
            $display("FAIL single_pulse: ack/start/busy=%b expected 0001", {o_ack, o_pa_start, o_busy});
        end
        i_pa_finished = 1'b1; i_pa_x3 = 16'd3; i_pa_y3 = 16'd4; i_pa_z3 = 16'd5;
        tick();
        i_pa_finished = 1'b0;
        checks++;
        if (o_done !== 2'b10 || o_x3 !== 16'd3 || o_y3 !== 16'd4 || o_z3 !== 16'd5 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: done=%b res=(%0d,%0d,%0d) busy=%b expected 10 (3,4,5) 0",
                     o_done, o_x3, o_y3, o_z3, o_busy);
        end
        tick();
        checks++;
        if (o_done !== 2'b00) begin
            failures++;
            $display("FAIL single_done_pulse: done=%b expected 00", o_done);
        end
    endtask

    task automatic test_spurious_finish();
        i_pa_finished = 1'b1; i_pa_x3 = 16'd77; i_pa_y3 = 16'd78; i_pa_z3 = 16'd79;
        tick();
        i_pa_finished = 1'b0;
        tick();
        checks++;
        if (o_done !== 2'b00 || o_x3 !== 16'd3 || o_busy !== 1'b0 || o_ack !== 2'b00) begin
            failures++;
            $display("FAIL spurious: done=%b x3=%0d busy=%b ack=%b expected 00 3 0 00",
                     o_done, o_x3, o_busy, o_ack);
        end
    endtask

    task automatic test_hold_operands();
        i_req = 2'b10; i_dbl = 2'b00;
        i_x1[1] = 16'd11; i_y1[1] = 16'd12; i_z1[1] = 16'd13;
        i_x2[1] = 16'd21; i_y2[1] = 16'd22; i_z2[1] = 16'd23;
        tick();
        i_x1[1] = 16'd99; i_y1[1] = 16'd98; i_z1[1] = 16'd97;
        i_x2[1] = 16'd96; i_y2[1] = 16'd95; i_z2[1] = 16'd94; i_dbl = 2'b10;
        tick(); tick();
        checks++;
        if ({o_pa_x1, o_pa_y1, o_pa_z1} !== {16'd11, 16'd12, 16'd13} ||
            {o_pa_x2, o_pa_y2, o_pa_z2} !== {16'd21, 16'd22, 16'd23} || o_pa_doubling !== 1'b0) begin
            failures++;
            $display("FAIL hold_ops: pa=(%0d,%0d,%0d)(%0d,%0d,%0d) dbl=%b expected (11,12,13)(21,22,23) 0",
                     o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2, o_pa_doubling);
        end
        i_req = 2'b00;
        i_pa_finished = 1'b1; i_pa_x3 = 16'd40; i_pa_y3 = 16'd41; i_pa_z3 = 16'd42;
        tick();
        i_pa_finished = 1'b0;
        checks++;
        if (o_done !== 2'b10 || o_pa_x1 !== 16'd11 || o_x3 !== 16'd40) begin
            failures++;
            $display("FAIL hold_done: done=%b pa_x1=%0d x3=%0d expected 10 11 40", o_done, o_pa_x1, o_x3);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_owner;
        i_req = 2'b11; i_dbl = 2'b01;
        tick();
        for (int j = 0; j < 4; j++) begin
`ifdef PADD_ARB_RR_EN
            exp_owner = (j % 2 == 1);
`else
            exp_owner = 1'b0;
`endif
            checks++;
            if (o_owner !== exp_owner || o_ack !== 2'(2'b01 << exp_owner) || o_pa_start !== 1'b1) begin
                failures++;
                $display("FAIL b2b_grant[%0d]: owner=%b ack=%b start=%b expected owner=%b",
                         j, o_owner, o_ack, o_pa_start, exp_owner);
            end
            i_pa_finished = 1'b1; i_pa_x3 = 16'(100 + j);
            tick();
            i_pa_finished = 1'b0;
            checks++;
            if (o_done !== 2'(2'b01 << exp_owner) || o_x3 !== 16'(100 + j)) begin
                failures++;
                $display("FAIL b2b_done[%0d]: done=%b x3=%0d expected owner=%b x3=%0d",
                         j, o_done, o_x3, exp_owner, 100 + j);
            end
            if (j == 3) i_req = 2'b00;
            tick();
        end
        checks++;
        if (o_busy !== 1'b0 || o_ack !== 2'b00) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b ack=%b expected 0 00", o_busy, o_ack);
        end
    endtask

    task automatic test_reset_busy();
        i_req = 2'b01; i_dbl = 2'b00;
        i_x1[0] = 16'd5; i_y1[0] = 16'd6; i_z1[0] = 16'd7;
        tick();
        i_req = 2'b00;
        tick(); tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if ({o_busy, o_owner, o_ack, o_done, o_pa_start} !== 7'b0 ||
            {o_pa_x1, o_pa_y1, o_x3, o_y3, o_z3} !== '0) begin
            failures++;
            $display("FAIL rst_busy: busy=%b owner=%b ack=%b done=%b pa_x1=%0d x3=%0d expected all 0",
                     o_busy, o_owner, o_ack, o_done, o_pa_x1, o_x3);
        end
        i_pa_finished = 1'b1; i_pa_x3 = 16'd55;
        tick();
        i_pa_finished = 1'b0;
        tick();
        checks++;
        if (o_done !== 2'b00 || o_x3 !== 16'd0) begin
            failures++;
            $display("FAIL rst_no_done: done=%b x3=%0d expected 00 0", o_done, o_x3);
        end
        i_req = 2'b10;
        tick();
        i_req = 2'b00;
        checks++;
        if (o_ack !== 2'b10 || o_pa_start !== 1'b1 || o_owner !== 1'b1) begin
            failures++;
            $display("FAIL rst_fresh: ack=%b start=%b owner=%b expected 10 1 1", o_ack, o_pa_start, o_owner);
        end
        i_pa_finished = 1'b1; i_pa_x3 = 16'd8;
        tick();
        i_pa_finished = 1'b0;
        checks++;
        if (o_done !== 2'b10 || o_x3 !== 16'd8) begin
            failures++;
            $display("FAIL rst_fresh_done: done=%b x3=%0d expected 10 8", o_done, o_x3);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_spurious_finish();
        test_hold_operands();
        test_back_to_back();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
